// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle control unit: state enumeration,
// opcode/funct constants and the datapath mux/ALU control codes.
package mc_control_fsm_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXECUTE = 4'd6,
        ST_ALUWB   = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_ADDIEX  = 4'd9,
        ST_ADDIWB  = 4'd10,
        ST_JUMP    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation select: R-type funct decode in EXECUTE, subtract for the
// branch compare, add everywhere else; flags unsupported funct codes.
module mc_alu_decoder
    import mc_control_fsm_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctl,
    output logic       funct_illegal
);

    always_comb begin
        alu_ctl       = ALU_ADD;
        funct_illegal = 1'b0;
        case (state)
            ST_EXECUTE: begin
                case (funct)
                    FN_ADD:  alu_ctl = ALU_ADD;
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            ST_BRANCH: alu_ctl = ALU_SUB;
            default:   alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle Moore control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with memory via MemReady and counts retired instructions.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWE,
    output logic             IorD,
    output logic             MemWE,
    output logic             MemReq,
    output logic             IRWE,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RFWE,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUCtl,
    output logic [1:0]       PCSrc,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] RetireCnt,
    output logic             IllegalOp
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic             retire;
    logic [2:0]       alu_ctl;
    logic             funct_illegal;

    mc_alu_decoder u_alu_decoder (
        .state         (state_q),
        .funct         (Funct),
        .alu_ctl       (alu_ctl),
        .funct_illegal (funct_illegal)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_FETCH;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        PCWE      = 1'b0;
        IorD      = 1'b0;
        MemWE     = 1'b0;
        MemReq    = 1'b0;
        IRWE      = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RFWE      = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_B;
        PCSrc     = PCSRC_ALU;
        IllegalOp = 1'b0;
        ALUCtl    = alu_ctl;

        case (state_q)
            ST_FETCH: begin
                MemReq  = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (MemReady) begin
                    IRWE    = 1'b1;
                    PCWE    = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Branch target is precomputed here so BRANCH can use ALUOut.
                ALUSrcB = SRCB_IMM_SH2;
                case (Opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXECUTE;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JUMP;
                    default: begin
                        IllegalOp = 1'b1;
                        state_d   = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (Opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                MemReq = 1'b1;
                IorD   = 1'b1;
                if (MemReady) begin
                    state_d = ST_MEMWB;
                end
            end
            ST_MEMWB: begin
                RFWE     = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_MEMWR: begin
                MemReq = 1'b1;
                IorD   = 1'b1;
                MemWE  = 1'b1;
                if (MemReady) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_EXECUTE: begin
                ALUSrcA = 1'b1;
                if (funct_illegal) begin
                    IllegalOp = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_ALUWB;
                end
            end
            ST_ALUWB: begin
                RFWE    = 1'b1;
                RegDst  = 1'b1;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                ALUSrcA = 1'b1;
                PCSrc   = PCSRC_ALUOUT;
                PCWE    = Zero;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                RFWE    = 1'b1;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_JUMP: begin
                PCSrc   = PCSRC_JUMP;
                PCWE    = 1'b1;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        retire_cnt_d = retire ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;

        // Reset overrides everything so an in-flight write is dropped this cycle.
        if (RST) begin
            PCWE      = 1'b0;
            IorD      = 1'b0;
            MemWE     = 1'b0;
            MemReq    = 1'b0;
            IRWE      = 1'b0;
            RegDst    = 1'b0;
            MemtoReg  = 1'b0;
            RFWE      = 1'b0;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 2'b00;
            ALUCtl    = 3'b000;
            PCSrc     = 2'b00;
            IllegalOp = 1'b0;
        end
    end

    assign State     = RST ? 4'd0 : state_q;
    assign RetireCnt = RST ? '0 : retire_cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized + directed bench for mc_control_fsm: each instruction is expanded
// into its expected state trace and every cycle is checked against it.
module tb_mc_control_fsm;
    import mc_control_fsm_pkg::*;

    localparam int CNT_W = 5;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [5:0]       Opcode = '0;
    logic [5:0]       Funct = '0;
    logic             Zero = 1'b0;
    logic             MemReady = 1'b0;
    logic             PCWE, IorD, MemWE, MemReq, IRWE, RegDst, MemtoReg, RFWE;
    logic             ALUSrcA, IllegalOp;
    logic [1:0]       ALUSrcB, PCSrc;
    logic [2:0]       ALUCtl;
    logic [3:0]       State;
    logic [CNT_W-1:0] RetireCnt;

    mc_control_fsm #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .PCWE(PCWE), .IorD(IorD), .MemWE(MemWE),
        .MemReq(MemReq), .IRWE(IRWE), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RFWE(RFWE), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtl(ALUCtl),
        .PCSrc(PCSrc), .State(State), .RetireCnt(RetireCnt), .IllegalOp(IllegalOp)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic pcwe, iord, memwe, memreq, irwe, regdst, memtoreg, rfwe, srca;
        logic [1:0] srcb;
        logic [2:0] aluctl;
        logic [1:0] pcsrc;
        logic illegal;
    } ctl_t;

    typedef struct {
        state_e st;
        logic   rdy;
        bit     retire;
    } cyc_t;

    ctl_t obs;
    assign obs = {PCWE, IorD, MemWE, MemReq, IRWE, RegDst, MemtoReg, RFWE,
                  ALUSrcA, ALUSrcB, ALUCtl, PCSrc, IllegalOp};

    int n_checks = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    logic [5:0] good_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] bad_fn  [5] = '{6'h03, 6'h00, 6'h21, 6'h26, 6'h2B};
    logic [5:0] bad_op  [5] = '{6'h3F, 6'h01, 6'h10, 6'h2A, 6'h20};

    function automatic logic op_ok(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    endfunction

    function automatic void funct_alu(input logic [5:0] fn, output logic [2:0] ac,
                                      output logic ok);
        ok = 1'b1;
        ac = 3'b010;
        case (fn)
            6'h20:   ac = 3'b010;
            6'h22:   ac = 3'b110;
            6'h24:   ac = 3'b000;
            6'h25:   ac = 3'b001;
            6'h2A:   ac = 3'b111;
            default: ok = 1'b0;
        endcase
    endfunction

    // Expected control word and care-mask for one cycle, from the per-state table.
    function automatic void expect_ctl(input state_e st, input logic rdy, input logic zero,
                                       input logic [5:0] op, input logic [5:0] fn,
                                       output ctl_t e, output ctl_t m);
        logic [2:0] ac;
        logic       ok;
        e = '0;
        m = '0;
        m.pcwe = 1'b1; m.memwe = 1'b1; m.memreq = 1'b1;
        m.irwe = 1'b1; m.rfwe = 1'b1;  m.illegal = 1'b1;
        case (st)
            ST_FETCH: begin
                e.memreq = 1'b1; e.srcb = 2'b01; e.aluctl = 3'b010;
                e.irwe = rdy; e.pcwe = rdy;
                m.iord = 1'b1; m.srca = 1'b1; m.srcb = '1; m.aluctl = '1; m.pcsrc = '1;
            end
            ST_DECODE: begin
                e.srcb = 2'b11; e.aluctl = 3'b010; e.illegal = !op_ok(op);
                m.srca = 1'b1; m.srcb = '1; m.aluctl = '1;
            end
            ST_MEMADR, ST_ADDIEX: begin
                e.srca = 1'b1; e.srcb = 2'b10; e.aluctl = 3'b010;
                m.srca = 1'b1; m.srcb = '1; m.aluctl = '1;
            end
            ST_MEMRD: begin
                e.memreq = 1'b1; e.iord = 1'b1; m.iord = 1'b1;
            end
            ST_MEMWR: begin
                e.memreq = 1'b1; e.iord = 1'b1; e.memwe = 1'b1; m.iord = 1'b1;
            end
            ST_MEMWB: begin
                e.rfwe = 1'b1; e.memtoreg = 1'b1; m.regdst = 1'b1; m.memtoreg = 1'b1;
            end
            ST_ALUWB: begin
                e.rfwe = 1'b1; e.regdst = 1'b1; m.regdst = 1'b1; m.memtoreg = 1'b1;
            end
            ST_ADDIWB: begin
                e.rfwe = 1'b1; m.regdst = 1'b1; m.memtoreg = 1'b1;
            end
            ST_EXECUTE: begin
                funct_alu(fn, ac, ok);
                e.srca = 1'b1; m.srca = 1'b1; m.srcb = '1;
                if (ok) begin
                    e.aluctl = ac; m.aluctl = '1;
                end else begin
                    e.illegal = 1'b1;
                end
            end
            ST_BRANCH: begin
                e.srca = 1'b1; e.aluctl = 3'b110; e.pcsrc = 2'b01; e.pcwe = zero;
                m.srca = 1'b1; m.srcb = '1; m.aluctl = '1; m.pcsrc = '1;
            end
            ST_JUMP: begin
                e.pcsrc = 2'b10; e.pcwe = 1'b1; m.pcsrc = '1;
            end
            default: ;
        endcase
    endfunction

    task automatic check_cnt(input string tag);
        n_checks++;
        assert (RetireCnt === CNT_W'(exp_cnt)) else begin
            n_fail++;
            $error("FAIL %s: RetireCnt got %0d expected %0d", tag, RetireCnt, exp_cnt);
        end
    endtask

    task automatic reset_cycle();
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        assert (obs === ctl_t'('0)) else begin
            n_fail++;
            $error("FAIL reset_ctl: got %h expected %h", obs, 17'h0);
        end
        n_checks++;
        assert (State === 4'd0) else begin
            n_fail++;
            $error("FAIL reset_state: got %0d expected 0", State);
        end
        exp_cnt = 0;
        check_cnt("reset_cnt");
        @(posedge CLK);
        #1;
    endtask

    task automatic run_cycle(input cyc_t c, input logic zero, input logic [5:0] op,
                             input logic [5:0] fn);
        ctl_t e, m;
        RST = 1'b0;
        Opcode = op;
        Funct = fn;
        Zero = zero;
        MemReady = c.rdy;
        @(negedge CLK);
        expect_ctl(c.st, c.rdy, zero, op, fn, e, m);
        n_checks++;
        assert (State === 4'(c.st)) else begin
            n_fail++;
            $error("FAIL state: got %0d expected %0d (op %h)", State, c.st, op);
        end
        n_checks++;
        assert ((obs & m) === (e & m)) else begin
            n_fail++;
            $error("FAIL ctl st=%0d op=%h fn=%h: got %h expected %h (mask %h)",
                   c.st, op, fn, obs & m, e & m, m);
        end
        check_cnt("cnt");
        @(posedge CLK);
        #1;
        if (c.retire) exp_cnt = (exp_cnt + 1) % CNT_MOD;
    endtask

    // Expands one instruction into its cycle trace; abort_last swaps the final
    // cycle for a reset cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                             input int fwait, input int mwait, input bit abort_last);
        cyc_t q[$];
        logic [2:0] ac;
        logic ok;
        for (int i = 0; i < fwait; i++) q.push_back('{ST_FETCH, 1'b0, 1'b0});
        q.push_back('{ST_FETCH, 1'b1, 1'b0});
        q.push_back('{ST_DECODE, 1'($urandom), 1'b0});
        case (op)
            6'h00: begin
                funct_alu(fn, ac, ok);
                q.push_back('{ST_EXECUTE, 1'($urandom), 1'b0});
                if (ok) q.push_back('{ST_ALUWB, 1'($urandom), 1'b1});
            end
            6'h23: begin
                q.push_back('{ST_MEMADR, 1'($urandom), 1'b0});
                for (int i = 0; i < mwait; i++) q.push_back('{ST_MEMRD, 1'b0, 1'b0});
                q.push_back('{ST_MEMRD, 1'b1, 1'b0});
                q.push_back('{ST_MEMWB, 1'($urandom), 1'b1});
            end
            6'h2B: begin
                q.push_back('{ST_MEMADR, 1'($urandom), 1'b0});
                for (int i = 0; i < mwait; i++) q.push_back('{ST_MEMWR, 1'b0, 1'b0});
                q.push_back('{ST_MEMWR, 1'b1, 1'b1});
            end
            6'h04: q.push_back('{ST_BRANCH, 1'($urandom), 1'b1});
            6'h08: begin
                q.push_back('{ST_ADDIEX, 1'($urandom), 1'b0});
                q.push_back('{ST_ADDIWB, 1'($urandom), 1'b1});
            end
            6'h02: q.push_back('{ST_JUMP, 1'($urandom), 1'b1});
            default: ;
        endcase
        for (int i = 0; i < q.size(); i++) begin
            if (abort_last && i == q.size() - 1) reset_cycle();
            else run_cycle(q[i], zero, op, fn);
        end
        $display("instr op=%h fn=%h zero=%0b cycles=%0d abort=%0b retired=%0d",
                 op, fn, zero, q.size(), abort_last, exp_cnt);
    endtask

    initial begin
        int sel;
        logic [5:0] op, fn;
        reset_cycle();
        reset_cycle();

        run_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);
        check_cnt("first_retire");
        run_instr(6'h23, 6'h00, 1'b0, 0, 3, 1'b0);
        run_instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b0);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0, 1'b0);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 0, 1'b0);
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);
        run_instr(6'h00, 6'h03, 1'b0, 0, 0, 1'b0);
        run_instr(6'h08, 6'h00, 1'b0, 1, 0, 1'b0);
        run_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0);

        // Reset lands on the MEMWB cycle of a load.
        run_instr(6'h23, 6'h00, 1'b0, 0, 1, 1'b1);
        run_instr(6'h08, 6'h00, 1'b0, 0, 0, 1'b0);

        // Drive the counter to its top value, then retire once more to wrap it.
        for (int i = 0; i < CNT_MOD && exp_cnt != CNT_MOD - 1; i++)
            run_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0);
        run_instr(6'h08, 6'h00, 1'b0, 0, 0, 1'b0);
        n_checks++;
        assert (RetireCnt === '0) else begin
            n_fail++;
            $error("FAIL wrap: RetireCnt got %0d expected 0", RetireCnt);
        end

        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 7);
            fn  = good_fn[$urandom_range(0, 4)];
            case (sel)
                0: op = 6'h00;
                1: begin op = 6'h00; fn = bad_fn[$urandom_range(0, 4)]; end
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                5: op = 6'h08;
                6: op = 6'h02;
                default: op = bad_op[$urandom_range(0, 4)];
            endcase
            run_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                      ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multicycle control unit that sits directly upstream of the register file and sequences each instruction through fetch, decode, execute, memory and writeback. It drives RFWE, RegDst and MemtoReg into the register-file write port, and drives the PC, IR, memory and ALU-mux enables. It is a Moore FSM with a memory-ready handshake and a retired-instruction counter. Supported subset: R-type (add, sub, and, or, slt), lw, sw, beq, addi, j.

Parameters:
CNT_W, 32, width of retired-instruction counter
OP_RTYPE, 6'h00, R-type opcode; OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04, OP_ADDI=6'h08, OP_J=6'h02

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous active-high reset
Opcode  input  6  IR[31:26]
Funct  input  6  IR[5:0]
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes the access this cycle
PCWE  output  1  PC write enable
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemWE  output  1  data memory write enable
MemReq  output  1  memory access request
IRWE  output  1  instruction register write enable
RegDst  output  1  RF write address select: 0=rt, 1=rd
MemtoReg  output  1  RF write data select: 0=ALUOut, 1=MDR
RFWE  output  1  register file write enable
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
ALUCtl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
State  output  4  current state, for debug
RetireCnt  output  CNT_W  retired-instruction count
IllegalOp  output  1  one-cycle pulse on an unsupported opcode or funct

Behaviour:
- While RST=1: state<=FETCH, RetireCnt<=0. All enables (PCWE, MemWE, MemReq, IRWE, RFWE) and IllegalOp are forced to 0. All other outputs are 0.
- Outputs are decoded combinationally from the state. Exceptions: PCWE in BRANCH equals Zero; ALUCtl in EXECUTE is decoded from Funct.
- FETCH: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtl=add, PCSrc=00. IRWE and PCWE assert only in the cycle MemReady=1, and the FSM then moves to DECODE. Otherwise it holds in FETCH with no writes.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUCtl=add (branch target goes to ALUOut). Next state: lw/sw->MEMADR, R->EXECUTE, beq->BRANCH, addi->ADDIEX, j->JUMP. Any other opcode->FETCH with IllegalOp=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUCtl=add. Next state: lw->MEMRD, sw->MEMWR.
- MEMRD: MemReq=1, IorD=1. Holds until MemReady=1, then goes to MEMWB.
- MEMWB: RFWE=1, RegDst=0, MemtoReg=1. Next state is FETCH; the instruction retires.
- MEMWR: MemReq=1, IorD=1, MemWE=1. MemWE is held until MemReady=1, then the FSM goes to FETCH and the instruction retires.
- EXECUTE: ALUSrcA=1, ALUSrcB=00. ALUCtl from Funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. Any other funct: IllegalOp=1, next state FETCH, no writeback, no retire. Otherwise next state is ALUWB.
- ALUWB: RFWE=1, RegDst=1, MemtoReg=0. Next state FETCH; retires.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUCtl=sub, PCSrc=01, PCWE=Zero. Next state FETCH; retires.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUCtl=add. Next state ADDIWB.
- ADDIWB: RFWE=1, RegDst=0, MemtoReg=0. Next state FETCH; retires.
- JUMP: PCSrc=10, PCWE=1. Next state FETCH; retires.
- RetireCnt increments by 1 on the last cycle of each retired instruction and wraps modulo 2^CNT_W.
- RST asserted mid-instruction: all in-flight writes are abandoned that cycle, and no RFWE or MemWE is seen on the reset cycle.
- Cycle counts with MemReady tied high: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- RFWE asserts for exactly one cycle per writing instruction and never in FETCH or DECODE.
- The FSM makes no special case for register 0; the register file owns that behaviour.

Decomposition:
- Shared package holds the state enumeration (4-bit encoding), opcode and funct constants, and the ALUCtl, ALUSrcB and PCSrc codes.
- One sub-module is natural: mc_alu_decoder, combinational Funct/state -> ALUCtl plus its IllegalOp contribution.
- The FSM register, output decode and counter stay in the top module.

Test Plan:
- RST=1 for 2 cycles, then release with MemReady=1 and Opcode=0x00, Funct=0x20 -> states FETCH, DECODE, EXECUTE, ALUWB; RFWE=1 only in cycle 4 with RegDst=1; RetireCnt=1.
- lw (0x23) with MemReady low for 3 cycles in MEMRD -> MEMRD held 4 cycles; RFWE=1 with MemtoReg=1 exactly once; MemWE never 1.
- beq (0x04), once with Zero=1 and once with Zero=0 -> PCWE=1 with PCSrc=01 in BRANCH for the Zero=1 case only; RetireCnt increments in both cases.
- sw (0x2B) -> MemWE=1 with IorD=1 for 1 cycle; RFWE stays 0; 4-cycle instruction.
- Opcode 0x3F, then R-type with Funct 0x03 -> IllegalOp pulses for 1 cycle in each case; FSM returns to FETCH; RFWE=0; RetireCnt unchanged.
- RST asserted during MEMWB of lw -> RFWE=0 that cycle, State=FETCH the next cycle, RetireCnt=0; also preload the counter to 2^CNT_W-1 and retire one instruction -> RetireCnt wraps to 0.
